// File: rtl/data_bus_ctrl_if.sv
// Bundle of the two master request ports and the d_mem / I/O slave ports around data_bus_ctrl.
// "slave" is the controller's view; "master" is the surrounding system (requesters and memories).
interface data_bus_ctrl_if;
    logic        m0_req,    m1_req;
    logic [31:0] m0_addr,   m1_addr;
    logic        m0_we,     m1_we;
    logic [31:0] m0_wdata,  m1_wdata;
    logic [3:0]  m0_mask,   m1_mask;
    logic        m0_gnt,    m1_gnt;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata,  m1_rdata;
    logic        m0_err,    m1_err;

    logic [31:0] dmem_addr,  io_addr;
    logic [31:0] dmem_wdata, io_wdata;
    logic [3:0]  dmem_mask,  io_mask;
    logic        dmem_we, dmem_re, io_we, io_re;
    logic [31:0] dmem_rdata, io_rdata;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we,
        input  m0_wdata, m1_wdata, m0_mask, m1_mask,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
        output m0_rdata, m1_rdata, m0_err, m1_err,
        output dmem_addr, io_addr, dmem_wdata, io_wdata, dmem_mask, io_mask,
        output dmem_we, dmem_re, io_we, io_re,
        input  dmem_rdata, io_rdata
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we,
        output m0_wdata, m1_wdata, m0_mask, m1_mask,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
        input  m0_rdata, m1_rdata, m0_err, m1_err,
        input  dmem_addr, io_addr, dmem_wdata, io_wdata, dmem_mask, io_mask,
        input  dmem_we, dmem_re, io_we, io_re,
        output dmem_rdata, io_rdata
    );
endinterface

// File: rtl/data_bus_ctrl.sv
// Two-master data bus controller: round-robin arbitration, d_mem/I/O address decode with
// unmapped-access errors, and a registered one-cycle read response path back to the requester.
module data_bus_ctrl #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter logic [31:0] DMEM_BYTES = 32'd2048,
    parameter logic [31:0] IO_BASE    = 32'h8000_0000,
    parameter logic [31:0] IO_BYTES   = 32'd256
) (
    input  logic             clk,
    input  logic             rstn,
    data_bus_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DMEM = 2'd1,
        SRC_IO   = 2'd2
    } resp_src_e;

    logic        r_rr_last;
    logic        r_resp_valid;
    logic        r_resp_id;
    resp_src_e   r_resp_src;

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_any_gnt;
    logic        w_sel;

    logic [31:0] w_m_addr  [2];
    logic [31:0] w_m_wdata [2];
    logic [3:0]  w_m_mask  [2];
    logic [1:0]  w_m_we;

    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_mask;
    logic        w_we;

    logic [31:0] w_dmem_off;
    logic [31:0] w_io_off;
    logic        w_hit_dmem;
    logic        w_hit_io;
    resp_src_e   w_src;

    logic [31:0] w_resp_rdata;
    logic        w_resp_err;
    logic [1:0]  w_rvalid;
    logic [31:0] w_rdata [2];
    logic [1:0]  w_err;

    // Requests are masked by reset so grants and strobes stay low while rstn is asserted.
    assign w_req[0]     = bus.m0_req & rstn;
    assign w_req[1]     = bus.m1_req & rstn;
    assign w_m_addr[0]  = bus.m0_addr;
    assign w_m_addr[1]  = bus.m1_addr;
    assign w_m_wdata[0] = bus.m0_wdata;
    assign w_m_wdata[1] = bus.m1_wdata;
    assign w_m_mask[0]  = bus.m0_mask;
    assign w_m_mask[1]  = bus.m1_mask;
    assign w_m_we[0]    = bus.m0_we;
    assign w_m_we[1]    = bus.m1_we;

    // Under contention the master that was not granted last wins.
    always_comb begin
        w_gnt = 2'b00;
        if (w_req[0] && w_req[1]) begin
            if (r_rr_last) w_gnt = 2'b01;
            else           w_gnt = 2'b10;
        end else begin
            w_gnt = w_req;
        end
    end

    assign w_any_gnt = |w_gnt;
    assign w_sel     = w_gnt[1];

    assign w_addr  = w_m_addr[w_sel];
    assign w_wdata = w_m_wdata[w_sel];
    assign w_mask  = w_m_mask[w_sel];
    assign w_we    = w_m_we[w_sel];

    // Offset-then-compare makes addresses below a base wrap to large values and miss.
    assign w_dmem_off = w_addr - DMEM_BASE;
    assign w_io_off   = w_addr - IO_BASE;
    assign w_hit_dmem = (w_dmem_off < DMEM_BYTES);
    assign w_hit_io   = (w_io_off < IO_BYTES) && !w_hit_dmem;

    always_comb begin
        w_src = SRC_NONE;
        if (w_hit_dmem)    w_src = SRC_DMEM;
        else if (w_hit_io) w_src = SRC_IO;
    end

    assign bus.m0_gnt = w_gnt[0];
    assign bus.m1_gnt = w_gnt[1];

    assign bus.dmem_addr  = w_addr;
    assign bus.dmem_wdata = w_wdata;
    assign bus.dmem_mask  = w_mask;
    assign bus.io_addr    = w_addr;
    assign bus.io_wdata   = w_wdata;
    assign bus.io_mask    = w_mask;

    assign bus.dmem_we = w_any_gnt & w_hit_dmem &  w_we;
    assign bus.dmem_re = w_any_gnt & w_hit_dmem & !w_we;
    assign bus.io_we   = w_any_gnt & w_hit_io   &  w_we;
    assign bus.io_re   = w_any_gnt & w_hit_io   & !w_we;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_last <= 1'b1;
        end else if (w_any_gnt) begin
            r_rr_last <= w_sel;
        end
    end

    // Every granted read, mapped or not, earns exactly one response on the next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_src   <= SRC_NONE;
        end else begin
            r_resp_valid <= w_any_gnt & !w_we;
            r_resp_id    <= w_sel;
            r_resp_src   <= w_src;
        end
    end

    always_comb begin
        w_resp_rdata = 32'h0;
        w_resp_err   = 1'b0;
        case (r_resp_src)
            SRC_DMEM: w_resp_rdata = bus.dmem_rdata;
            SRC_IO:   w_resp_rdata = bus.io_rdata;
            default:  w_resp_err   = 1'b1;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign w_rvalid[gi] = r_resp_valid && (r_resp_id == 1'(gi));
            assign w_rdata[gi]  = w_rvalid[gi] ? w_resp_rdata : 32'h0;
            assign w_err[gi]    = w_rvalid[gi] & w_resp_err;
        end
    endgenerate

    assign bus.m0_rvalid = w_rvalid[0];
    assign bus.m1_rvalid = w_rvalid[1];
    assign bus.m0_rdata  = w_rdata[0];
    assign bus.m1_rdata  = w_rdata[1];
    assign bus.m0_err    = w_err[0];
    assign bus.m1_err    = w_err[1];

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl: reset, arbitration, decode, response routing and boundaries.
module tb_data_bus_ctrl;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    data_bus_ctrl_if bus();

    data_bus_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        bus.m0_req = 1'b0; bus.m0_addr = 32'h0; bus.m0_we = 1'b0; bus.m0_wdata = 32'h0; bus.m0_mask = 4'h0;
        bus.m1_req = 1'b0; bus.m1_addr = 32'h0; bus.m1_we = 1'b0; bus.m1_wdata = 32'h0; bus.m1_mask = 4'h0;
    endtask

    logic [31:0] bnd_addr [4] = '{32'h0000_07FC, 32'h0000_0800, 32'h8000_00FF, 32'h7FFF_FFFF};
    logic        bnd_dmem [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        bnd_io   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] bnd_data [4] = '{32'hCAFE_F00D, 32'h0, 32'h0000_0001, 32'h0};

    initial begin
        idle_masters();
        bus.dmem_rdata = 32'h0;
        bus.io_rdata   = 32'h0;

        // Reset held with both masters requesting reads.
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0010; bus.m0_we = 1'b0; bus.m0_mask = 4'hF;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h8000_0000; bus.m1_we = 1'b0; bus.m1_mask = 4'hF;
        tick(); tick();
        check("rst_m0_gnt",    32'(bus.m0_gnt),    32'h0);
        check("rst_m1_gnt",    32'(bus.m1_gnt),    32'h0);
        check("rst_dmem_re",   32'(bus.dmem_re),   32'h0);
        check("rst_io_re",     32'(bus.io_re),     32'h0);
        check("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
        check("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
        check("rst_m0_rdata",  bus.m0_rdata,       32'h0);

        bus.dmem_rdata = 32'hCAFE_F00D;
        bus.io_rdata   = 32'h0000_0001;
        rstn = 1'b1;
        #1;
        check("rel_m0_gnt",    32'(bus.m0_gnt),  32'h1);
        check("rel_m1_gnt",    32'(bus.m1_gnt),  32'h0);
        check("rel_dmem_re",   32'(bus.dmem_re), 32'h1);
        check("rel_io_re",     32'(bus.io_re),   32'h0);
        check("rel_dmem_addr", bus.dmem_addr,    32'h0000_0010);

        tick();
        check("rd0_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
        check("rd0_m0_rdata",  bus.m0_rdata,       32'hCAFE_F00D);
        check("rd0_m0_err",    32'(bus.m0_err),    32'h0);
        check("rd0_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
        check("rr_m1_gnt",     32'(bus.m1_gnt),    32'h1);
        check("rr_m0_gnt",     32'(bus.m0_gnt),    32'h0);
        check("rr_io_re",      32'(bus.io_re),     32'h1);
        bus.m0_req = 1'b0;

        tick();
        check("rd1_m1_rvalid", 32'(bus.m1_rvalid), 32'h1);
        check("rd1_m1_rdata",  bus.m1_rdata,       32'h0000_0001);
        check("rd1_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
        check("rd1_m0_rdata",  bus.m0_rdata,       32'h0);
        idle_masters();

        // Contending writes alternate, m0 first (m1 was granted last).
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0004; bus.m0_we = 1'b1; bus.m0_wdata = 32'hAAAA_0000; bus.m0_mask = 4'h3;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h8000_0000; bus.m1_we = 1'b1; bus.m1_wdata = 32'hBBBB_0000; bus.m1_mask = 4'hC;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("wr%0d_m0_gnt", i),  32'(bus.m0_gnt),  (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("wr%0d_m1_gnt", i),  32'(bus.m1_gnt),  (i % 2 == 1) ? 32'h1 : 32'h0);
            check($sformatf("wr%0d_dmem_we", i), 32'(bus.dmem_we), (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("wr%0d_io_we", i),   32'(bus.io_we),   (i % 2 == 1) ? 32'h1 : 32'h0);
            if (i % 2 == 0) begin
                check($sformatf("wr%0d_dmem_mask", i),  32'(bus.dmem_mask), 32'h3);
                check($sformatf("wr%0d_dmem_wdata", i), bus.dmem_wdata,     32'hAAAA_0000);
            end else begin
                check($sformatf("wr%0d_io_mask", i),  32'(bus.io_mask), 32'hC);
                check($sformatf("wr%0d_io_wdata", i), bus.io_wdata,     32'hBBBB_0000);
            end
            tick();
        end
        check("wr_no_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
        check("wr_no_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
        idle_masters();

        // m1 io read immediately followed by an m0 dmem read.
        bus.dmem_rdata = 32'h1234_5678;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h8000_0000; bus.m1_we = 1'b0;
        #1;
        check("b2b_m1_gnt", 32'(bus.m1_gnt), 32'h1);
        check("b2b_io_re",  32'(bus.io_re),  32'h1);
        tick();
        bus.m1_req = 1'b0;
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0020; bus.m0_we = 1'b0;
        #1;
        check("b2b_m1_rvalid", 32'(bus.m1_rvalid), 32'h1);
        check("b2b_m1_rdata",  bus.m1_rdata,       32'h0000_0001);
        check("b2b_m0_gnt",    32'(bus.m0_gnt),    32'h1);
        check("b2b_dmem_re",   32'(bus.dmem_re),   32'h1);
        tick();
        check("b2b_m0_rvalid",  32'(bus.m0_rvalid), 32'h1);
        check("b2b_m0_rdata",   bus.m0_rdata,       32'h1234_5678);
        check("b2b_m1_rvalid2", 32'(bus.m1_rvalid), 32'h0);
        idle_masters();

        // Unmapped read, then unmapped write to the same address.
        bus.m0_req = 1'b1; bus.m0_addr = 32'h4000_0000; bus.m0_we = 1'b0;
        #1;
        check("um_rd_gnt",     32'(bus.m0_gnt),  32'h1);
        check("um_rd_dmem_re", 32'(bus.dmem_re), 32'h0);
        check("um_rd_io_re",   32'(bus.io_re),   32'h0);
        tick();
        check("um_rd_rvalid", 32'(bus.m0_rvalid), 32'h1);
        check("um_rd_err",    32'(bus.m0_err),    32'h1);
        check("um_rd_rdata",  bus.m0_rdata,       32'h0);
        bus.m0_we = 1'b1; bus.m0_wdata = 32'hDEAD_BEEF; bus.m0_mask = 4'hF;
        #1;
        check("um_wr_gnt",     32'(bus.m0_gnt),  32'h1);
        check("um_wr_dmem_we", 32'(bus.dmem_we), 32'h0);
        check("um_wr_io_we",   32'(bus.io_we),   32'h0);
        tick();
        check("um_wr_rvalid", 32'(bus.m0_rvalid), 32'h0);
        check("um_wr_err",    32'(bus.m0_err),    32'h0);
        idle_masters();

        // Decode boundaries, one m0 read per cycle.
        bus.dmem_rdata = 32'hCAFE_F00D;
        bus.io_rdata   = 32'h0000_0001;
        for (int i = 0; i < 4; i++) begin
            bus.m0_req = 1'b1; bus.m0_addr = bnd_addr[i]; bus.m0_we = 1'b0;
            #1;
            check($sformatf("bnd_%h_dmem_re", bnd_addr[i]), 32'(bus.dmem_re), 32'(bnd_dmem[i]));
            check($sformatf("bnd_%h_io_re", bnd_addr[i]),   32'(bus.io_re),   32'(bnd_io[i]));
            tick();
            check($sformatf("bnd_%h_rvalid", bnd_addr[i]), 32'(bus.m0_rvalid), 32'h1);
            check($sformatf("bnd_%h_err", bnd_addr[i]),    32'(bus.m0_err),    32'(!bnd_dmem[i] && !bnd_io[i]));
            check($sformatf("bnd_%h_rdata", bnd_addr[i]),  bus.m0_rdata,       bnd_data[i]);
        end
        idle_masters();
        tick();

        // Reset asserted while a read response is pending.
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0010; bus.m0_we = 1'b0;
        #1;
        check("mr_m0_gnt", 32'(bus.m0_gnt), 32'h1);
        tick();
        bus.m0_req = 1'b0;
        rstn = 1'b0;
        #1;
        check("mr_rst_rvalid", 32'(bus.m0_rvalid), 32'h0);
        tick();
        rstn = 1'b1;
        #1;
        check("mr_rel_rvalid", 32'(bus.m0_rvalid), 32'h0);
        tick();
        check("mr_post_rvalid", 32'(bus.m0_rvalid), 32'h0);
        check("mr_post_err",    32'(bus.m0_err),    32'h0);

        // Round-robin pointer returns to its reset value: m0 wins contention.
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0000; bus.m0_we = 1'b0;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h8000_0000; bus.m1_we = 1'b0;
        #1;
        check("mr_rr_m0_gnt", 32'(bus.m0_gnt), 32'h1);
        check("mr_rr_m1_gnt", 32'(bus.m1_gnt), 32'h0);
        idle_masters();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_bus_ctrl.md
Name: data_bus_ctrl

Overview:
Data-side bus controller between two bus masters and the data-memory and memory-mapped I/O slaves.
- Masters: m0 = core data port, m1 = debug/DMA port.
- Per cycle: round-robin arbitration, address decode to the d_mem or I/O slave, and strobe generation.
- Read responses are routed back to the issuing master through a registered one-cycle response pipeline.
- It replaces the ad-hoc read-data mux (SPI status precedence) with proper address decode, and flags unmapped accesses as errors.

Parameters:
DMEM_BASE  32'h0000_0000  byte base address of data memory
DMEM_BYTES 2048  data memory size in bytes; power of two
IO_BASE  32'h8000_0000  byte base address of the I/O window
IO_BYTES  256  I/O window size in bytes; power of two

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
m0_req, m1_req  in  1 each  access request, held until granted
m0_addr, m1_addr  in  32 each  byte address
m0_we, m1_we  in  1 each  1 = write, 0 = read
m0_wdata, m1_wdata  in  32 each  write data
m0_mask, m1_mask  in  4 each  byte-enable mask
m0_gnt, m1_gnt  out  1 each  access accepted this cycle
m0_rvalid, m1_rvalid  out  1 each  read response valid
m0_rdata, m1_rdata  out  32 each  read response data
m0_err, m1_err  out  1 each  response is for an unmapped address
dmem_addr, io_addr  out  32 each  slave address, passed through from the granted master
dmem_wdata, io_wdata  out  32 each  slave write data
dmem_mask, io_mask  out  4 each  slave byte mask
dmem_we, dmem_re, io_we, io_re  out  1 each  slave strobes
dmem_rdata, io_rdata  in  32 each  slave read data, valid 1 cycle after the re strobe

Behaviour:
- Reset (async, rstn low):
  - Response pipeline cleared: all rvalid/err 0, all rdata 0.
  - rr_last = 1, so m0 wins the first contention.
  - While rstn is low, all gnt and all slave strobes are forced 0.
- Arbitration (combinational, every cycle, no idle cycle needed between grants):
  - Only one requester: it is granted.
  - Both requesting: the master ≠ rr_last is granted.
  - rr_last updates on the clock edge to the granted index; it is unchanged when nothing is granted.
- Decode of the granted address:
  - hit_dmem = (addr - DMEM_BASE) < DMEM_BYTES.
  - hit_io = (addr - IO_BASE) < IO_BYTES.
  - Unsigned 32-bit compare; wrap-around below a base is a miss.
  - Neither hit = unmapped.
- Slave strobes (same cycle as gnt):
  - Selected slave gets addr/wdata/mask of the granted master, plus we = m_we or re = !m_we.
  - Non-selected slave strobes are 0; its addr/wdata/mask are don't-care, driven from the granted master.
- Unmapped access:
  - Write: gnt asserted, no slave strobe; the write is dropped.
  - Read: gnt asserted, no strobe; a response is still generated.
- Response pipeline (registered):
  - On a granted read, next edge sets resp_valid = 1, resp_id = granted master, resp_src = {dmem, io, none}.
  - Otherwise resp_valid = 0 on the next edge.
  - The cycle after the grant, mX_rvalid = resp_valid & (resp_id == X).
  - rdata comes from dmem_rdata or io_rdata per resp_src; for none, rdata = 32'h0 and err = 1.
  - rdata/err of the non-addressed master are 0.
- Read latency: exactly 1 cycle from grant to rvalid. Back-to-back reads, including alternating masters, sustain one response per cycle.
- Writes produce no response; gnt is the completion.
- Requester rule: a master must hold req and its payload stable until gnt. The controller does not queue requests.
- Simultaneous response and new grant to the same master: legal. The previous read's rvalid and the new gnt may be high in the same cycle.
- Reset asserted mid-read: the pending response is discarded and no rvalid is produced after reset release.
- Slave-side requirements: slaves must accept an access every cycle and return read data with fixed 1-cycle latency. The I/O block holds its status register readable at IO_BASE.

Test Plan:
1. Reset: hold rstn = 0 with m0_req = 1 → all gnt, rvalid and strobes 0. Release → m0 granted on the first cycle.
2. m0 read of 0x0000_0010 with dmem returning 0xCAFE_F00D → dmem_re = 1 in the grant cycle. m0_rvalid = 1, m0_rdata = 0xCAFE_F00D next cycle; m1_rvalid = 0.
3. m0 and m1 both request writes (0x0000_0004, 0x8000_0000) for 4 cycles → grants alternate m0, m1, m0, m1. dmem_we and io_we alternate with the matching masks.
4. m1 read of 0x8000_0000, io_rdata = 0x0000_0001, immediately followed by an m0 dmem read → responses arrive on consecutive cycles to the correct masters, no bubble.
5. m0 read of 0x4000_0000 → m0_gnt = 1, no strobe. Next cycle m0_rvalid = 1, m0_err = 1, m0_rdata = 0. A write to the same address → no strobe, no response.
6. Boundaries: read 0x0000_07FC → dmem; 0x0000_0800 → err; 0x8000_00FF → io; 0x7FFF_FFFF → err. Also assert rstn mid-read → no rvalid after release.
